b16_uart_io: RTL and testbench

- Memory-mapped 8N1 UART peripheral for the b16 CPU.
- Occupies the I/O page at 0xFFFC–0xFFFF, the sel[2] decode slot in the top level.
- Consumes CPU bus cycles (r, w, dwrite, addr) and produces the 16-bit read data the top level muxes onto the CPU data bus.
- Drives UART_TXD and samples UART_RXD on the DE1 board.

---
 rtl/b16_uart_io.sv | 241 ++++++++++++++++++++++++
 tb/tb_b16_uart_io.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b16_uart_io.sv
// Memory-mapped 8N1 UART for the b16 I/O page: DATA (addr1=0) and STATUS (addr1=1).
// One-entry TX holding register in front of the shifter, small RX FIFO, sticky ferr/ovr.
module b16_uart_io #(
  parameter int unsigned DIV      = 434,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        r,
  input  logic [1:0]  w,
  input  logic        addr1,
  input  logic [15:0] dwrite,
  output logic [15:0] rdata,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        rx_avail
);

  localparam int unsigned AW     = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [15:0] DivM1  = 16'(DIV - 1);
  localparam logic [15:0] HalfM1 = 16'(DIV / 2 - 1);
  localparam logic [AW:0] Depth  = (AW + 1)'(RX_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic wr_data, rd_data, rd_stat;
  assign wr_data = cs & ~r & w[0] & ~addr1;
  assign rd_data = cs & r & ~addr1;
  assign rd_stat = cs & r & addr1;

  logic unused_bits;
  assign unused_bits = ^{w[1], dwrite[15:8]};

  // ---------------------------------------------------------------- TX
  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic        tx_full_q, tx_full_d;
  logic        txd_q, txd_d;
  logic        tx_load, tx_ready;

  assign tx_ready = ~tx_full_q;
  assign uart_txd = txd_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      StIdle: begin
        txd_d   = 1'b1;
        tx_load = tx_full_q;
      end
      StStart: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = StData;
          tx_cnt_d   = DivM1;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      StData: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = DivM1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = StStop;
            txd_d      = 1'b1;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (tx_cnt_q == 16'd0) begin
          // A full holding register chains straight into the next start bit.
          if (tx_full_q) tx_load = 1'b1;
          else           tx_state_d = StIdle;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = StIdle;
    endcase
    if (tx_load) begin
      tx_state_d = StStart;
      tx_cnt_d   = DivM1;
      tx_shift_d = tx_hold_q;
      tx_full_d  = 1'b0;
      txd_d      = 1'b0;
    end
    if (wr_data && tx_ready) begin
      tx_hold_d = dwrite[7:0];
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_hold_q  <= 8'h00;
      tx_full_q  <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------------------------------------------------------- RX
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_push, ferr_set, ovr_set;
  logic        ferr_q, ovr_q;

  logic [7:0]  mem_q [RX_DEPTH];
  logic [AW:0] wptr_q, rptr_q, count;
  logic        fifo_empty, fifo_full, pop;

  assign count      = wptr_q - rptr_q;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == Depth);
  assign pop        = rd_data & ~fifo_empty;
  assign rx_avail   = ~fifo_empty;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    ovr_set    = 1'b0;
    case (rx_state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = StStart;
          rx_cnt_d   = HalfM1;
        end
      end
      StStart: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) begin
            rx_state_d = StIdle;
          end else begin
            rx_state_d = StData;
            rx_cnt_d   = DivM1;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      StData: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = DivM1;
          if (rx_bit_q == 3'd7) rx_state_d = StStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = StIdle;
          // A same-cycle pop frees a slot in a full FIFO.
          if (!rx_s2_q)                ferr_set = 1'b1;
          else if (fifo_full && !pop)  ovr_set  = 1'b1;
          else                         rx_push  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      rx_s1_q    <= uart_rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      ferr_q     <= ferr_set | (ferr_q & ~rd_stat);
      ovr_q      <= ovr_set | (ovr_q & ~rd_stat);
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (rx_push) wptr_q <= wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) mem_q[wptr_q[AW-1:0]] <= rx_shift_d;
  end

  always_comb begin
    rdata = 16'h0000;
    if (addr1)            rdata = {12'h000, ferr_q, ovr_q, tx_ready, rx_avail};
    else if (!fifo_empty) rdata = {8'h00, mem_q[rptr_q[AW-1:0]]};
  end

endmodule

// File: tb/tb_b16_uart_io.sv
// Randomised and directed bench for b16_uart_io (DIV=8, RX_DEPTH=4) against a
// queue-based model of the serial line, holding register, RX FIFO and flags.
module tb_b16_uart_io;
  localparam int unsigned DIV      = 8;
  localparam int unsigned RX_DEPTH = 4;
  // 2 sync flops + edge register, half a bit to mid-start, 9 bits to mid-stop.
  localparam int unsigned RxLat    = 3 + DIV / 2 + 9 * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        r = 1'b0;
  logic [1:0]  w = 2'b00;
  logic        addr1 = 1'b1;
  logic [15:0] dwrite = 16'h0000;
  logic [15:0] rdata;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;
  logic        rx_avail;

  always #5 clk = ~clk;

  b16_uart_io #(.DIV(DIV), .RX_DEPTH(RX_DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .r        (r),
    .w        (w),
    .addr1    (addr1),
    .dwrite   (dwrite),
    .rdata    (rdata),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd),
    .rx_avail (rx_avail)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  typedef struct {
    int unsigned t;
    logic [7:0]  b;
    bit          ok;
  } rx_ev_t;

  bit          m_line[$];
  bit          m_txd = 1'b1;
  bit          m_hold_v = 1'b0;
  logic [7:0]  m_hold_b = 8'h00;
  logic [7:0]  m_fifo[$];
  bit          m_ferr = 1'b0;
  bit          m_ovr = 1'b0;
  rx_ev_t      m_pend[$];
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : model
    logic [9:0] fr;
    bit rd_d, rd_s, wr, old_hold;
    rx_ev_t ev;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_line.delete();
        m_fifo.delete();
        m_pend.delete();
        m_txd    = 1'b1;
        m_hold_v = 1'b0;
        m_ferr   = 1'b0;
        m_ovr    = 1'b0;
      end else begin
        rd_d = cs & r & ~addr1;
        rd_s = cs & r & addr1;
        wr   = cs & ~r & w[0] & ~addr1;
        old_hold = m_hold_v;
        if (m_line.size() == 0 && old_hold) begin
          fr = {1'b1, m_hold_b, 1'b0};
          for (int i = 0; i < 10; i++) repeat (DIV) m_line.push_back(fr[i]);
          m_hold_v = 1'b0;
        end
        if (wr && !old_hold) begin
          m_hold_v = 1'b1;
          m_hold_b = dwrite[7:0];
        end
        m_txd = (m_line.size() != 0) ? m_line.pop_front() : 1'b1;
        if (rd_d && m_fifo.size() != 0) void'(m_fifo.pop_front());
        if (rd_s) begin
          m_ferr = 1'b0;
          m_ovr  = 1'b0;
        end
        if (m_pend.size() != 0 && m_pend[0].t == cyc + 1) begin
          ev = m_pend.pop_front();
          if (!ev.ok)                       m_ferr = 1'b1;
          else if (m_fifo.size() < RX_DEPTH) m_fifo.push_back(ev.b);
          else                              m_ovr  = 1'b1;
        end
      end
    end
  end

  initial begin : compare
    logic [15:0] exp_rd;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (addr1)
          exp_rd = {12'h000, m_ferr, m_ovr, ~m_hold_v, m_fifo.size() != 0};
        else
          exp_rd = (m_fifo.size() != 0) ? {8'h00, m_fifo[0]} : 16'h0000;
        check("rdata", rdata, exp_rd);
        check("txd", 16'(uart_txd), 16'(m_txd));
        check("rx_avail", 16'(rx_avail), 16'(m_fifo.size() != 0));
      end
    end
  end

  // ------------------------------------------------------------ drivers
  task automatic idle_bus();
    cs = 1'b0; r = 1'b0; w = 2'b00; addr1 = 1'b1;
  endtask

  task automatic bus_op(input logic c, input logic rr, input logic [1:0] ww, input logic a,
                        input logic [15:0] d);
    @(posedge clk); #2;
    cs = c; r = rr; w = ww; addr1 = a; dwrite = d;
  endtask

  task automatic write_data(input logic [15:0] d);
    bus_op(1'b1, 1'b0, 2'b01, 1'b0, d);
    @(posedge clk); #2;
    idle_bus();
  endtask

  task automatic read_check(input string name, input logic a, input logic [15:0] exp);
    bus_op(1'b1, 1'b1, 2'b00, a, 16'h0000);
    #1 check(name, rdata, exp);
    @(posedge clk); #2;
    idle_bus();
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit ok);
    rx_ev_t ev;
    @(posedge clk); #2;
    uart_rxd = 1'b0;
    ev.t = cyc + RxLat;
    ev.b = b;
    ev.ok = ok;
    m_pend.push_back(ev);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk);
      #2 uart_rxd = b[i];
    end
    repeat (DIV) @(posedge clk);
    #2 uart_rxd = ok;
    repeat (DIV) @(posedge clk);
    #2 uart_rxd = 1'b1;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin : main
    logic [19:0] pat;
    pat = {1'b1, 8'hEF, 1'b0, 1'b1, 8'h55, 1'b0};

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("reset_status", rdata, 16'h0002);
    check("reset_rx_avail", 16'(rx_avail), 16'h0000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_txd", 16'(uart_txd), 16'h0001);
    end

    // TX: one frame, a back-to-back second frame, a dropped third write
    bus_op(1'b1, 1'b0, 2'b01, 1'b0, 16'h1255);
    @(posedge clk); #2;
    idle_bus();
    #1 check("tx_busy_status", rdata, 16'h0000);
    check("tx_not_started", 16'(uart_txd), 16'h0001);
    @(posedge clk); #3;
    check("tx_start_bit", 16'(uart_txd), 16'h0000);
    check("tx_ready_again", rdata, 16'h0002);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ((i == 0) ? 4 : 8) @(posedge clk);
          #3 check($sformatf("tx_bit%0d", i), 16'(uart_txd), 16'(pat[i]));
        end
      end
      begin
        repeat (10) @(posedge clk);
        write_data(16'hBEEF);
        write_data(16'h0077);
      end
    join
    repeat (100) @(posedge clk);
    #3 check("tx_idle_after", 16'(uart_txd), 16'h0001);

    // RX: single frame
    rx_frame(8'hA3, 1'b1);
    #1 check("rx_avail_set", 16'(rx_avail), 16'h0001);
    read_check("rx_data_a3", 1'b0, 16'h00A3);
    #1 check("rx_avail_clr", 16'(rx_avail), 16'h0000);
    read_check("rx_status", 1'b1, 16'h0002);

    // RX: overrun with five frames into four entries
    for (int k = 1; k <= 5; k++) rx_frame(8'(k), 1'b1);
    read_check("ovr_status", 1'b1, 16'h0007);
    for (int k = 1; k <= 4; k++) read_check($sformatf("ovr_data%0d", k), 1'b0, 16'(k));
    read_check("ovr_status_clr", 1'b1, 16'h0002);

    // RX: framing error, then a short glitch
    rx_frame(8'h3C, 1'b0);
    repeat (2) @(posedge clk);
    read_check("ferr_status", 1'b1, 16'h000A);
    read_check("ferr_status_clr", 1'b1, 16'h0002);
    @(posedge clk); #2 uart_rxd = 1'b0;
    repeat (2) @(posedge clk);
    #2 uart_rxd = 1'b1;
    repeat (20) @(posedge clk);
    read_check("glitch_status", 1'b1, 16'h0002);

    // Random traffic on both directions
    fork
      begin
        for (int n = 0; n < 12; n++) begin
          repeat ($urandom_range(1, 10)) @(posedge clk);
          rx_frame(8'($urandom), $urandom_range(0, 5) != 0);
        end
      end
      begin
        for (int n = 0; n < 1100; n++) begin
          int unsigned op;
          op = $urandom_range(0, 31);
          if (op < 2)
            bus_op(1'b1, 1'b0, 2'($urandom_range(1, 3) | 1), 1'b0, 16'($urandom));
          else if (op == 2)
            bus_op(1'b1, 1'b0, 2'($urandom), 1'($urandom), 16'($urandom));
          else if (op == 3)
            bus_op(1'b1, 1'b1, 2'b00, 1'($urandom), 16'h0000);
          else if (op == 4)
            bus_op(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom));
          else
            bus_op(1'b1, 1'b0, 2'b00, 1'($urandom), 16'h0000);
        end
        @(posedge clk); #2;
        idle_bus();
      end
    join

    // Reset in the middle of a TX frame and an RX frame
    repeat (150) @(posedge clk);
    rx_frame(8'h99, 1'b1);
    #1 check("pre_reset_avail", 16'(rx_avail), 16'h0001);
    write_data(16'h0000);
    @(posedge clk); #2 uart_rxd = 1'b0;
    repeat (40) @(posedge clk);
    #2 check("pre_reset_txd", 16'(uart_txd), 16'h0000);
    #1 reset = 1'b1;
    #1 check("reset_txd", 16'(uart_txd), 16'h0001);
    check("reset_avail", 16'(rx_avail), 16'h0000);
    check("reset_status_async", rdata, 16'h0002);
    uart_rxd = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (5) @(posedge clk);
    read_check("post_reset_status", 1'b1, 16'h0002);
    read_check("post_reset_data", 1'b0, 16'h0000);
    repeat (20) @(posedge clk);
    #3 check("post_reset_txd", 16'(uart_txd), 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
